// File: rtl/font_dma_sched_if.sv
// font_dma_sched_if: requester/ROM-side bus of the font DMA scheduler.
interface font_dma_sched_if #(
  parameter int REQS  = 5,
  parameter int ADDRW = 9,
  parameter int DATAW = 8,
  parameter int CORDW = 10
);
  logic [CORDW-1:0]      sx;
  logic [REQS-1:0]       req;
  logic [REQS*ADDRW-1:0] req_addr;
  logic [ADDRW-1:0]      rom_addr;
  logic [DATAW-1:0]      rom_data;
  logic [REQS-1:0]       rsp_valid;
  logic [DATAW-1:0]      rsp_data;
  logic                  busy;
  logic                  overrun;
  modport master (input sx, req, req_addr, rom_data, output rom_addr, rsp_valid, rsp_data, busy, overrun);
  modport slave (output sx, req, req_addr, rom_data, input rom_addr, rsp_valid, rsp_data, busy, overrun);
endinterface

// File: rtl/font_dma_sched.sv
// font_dma_sched: round-robin font ROM arbiter granting read slots only in horizontal blanking.
// Define FDMA_STATS_EN to add the stat_overruns/stat_grants counters.
module font_dma_sched #(
  parameter int REQS       = 5,
  parameter int ADDRW      = 9,
  parameter int DATAW      = 8,
  parameter int CORDW      = 10,
  parameter int H_RES      = 640,
  parameter int H_RES_FULL = 800
) (
  input logic clk_pix,
  input logic rst,
  font_dma_sched_if.master bus
`ifdef FDMA_STATS_EN
  ,
  output logic [15:0] stat_overruns,
  output logic [7:0]  stat_grants
`endif
);
  localparam int PW = $clog2(REQS);
  typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, ptr_eff, g, ix, rr_nx;
  logic [REQS-1:0] grant_q, elig;
  logic [ADDRW-1:0] addr_a [REQS];
  logic win, found, ovr;
  for (genvar i = 0; i < REQS; i++) begin : g_addr
    assign addr_a[i] = bus.req_addr[i*ADDRW +: ADDRW];
  end
  // The sx==H_RES cycle already grants, so the window opens combinationally from IDLE
  always_comb begin
    win = !rst && (state == GRANT || (state == IDLE && bus.sx == CORDW'(H_RES)));
    state_nx = state == IDLE ? (bus.sx == CORDW'(H_RES) ? GRANT : IDLE) :
               state == GRANT ? (bus.sx == CORDW'(H_RES_FULL - 2) ? FLUSH : GRANT) : IDLE;
    ptr_eff = state == IDLE ? '0 : rr_ptr;
    elig = bus.req & ~grant_q;
    found = |elig;
    g = '0;
    ix = '0;
    for (int k = REQS - 1; k >= 0; k--) begin
      ix = PW'((int'(ptr_eff) + k) % REQS);
      g = elig[ix] ? ix : g;
    end
    rr_nx = g == PW'(REQS - 1) ? '0 : g + 1'b1;
    ovr = state == FLUSH && found;
  end
  always_ff @(posedge clk_pix or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_q <= '0;
    end else begin
      state <= state_nx;
      grant_q <= win && found ? REQS'(1) << g : '0;
      rr_ptr <= win ? (found ? rr_nx : ptr_eff) : rr_ptr;
    end
  assign bus.rom_addr = win && found ? addr_a[g] : '0;
  assign bus.rsp_valid = grant_q;
  assign bus.rsp_data = bus.rom_data;
  assign bus.busy = win;
  assign bus.overrun = ovr;
`ifdef FDMA_STATS_EN
  logic [7:0] win_cnt;
  always_ff @(posedge clk_pix or posedge rst)
    if (rst) begin
      stat_overruns <= '0;
      stat_grants <= '0;
      win_cnt <= '0;
    end else begin
      if (ovr && stat_overruns != '1) stat_overruns <= stat_overruns + 1'b1;
      if (win) win_cnt <= state == IDLE ? 8'(found) : (found && win_cnt != '1 ? win_cnt + 1'b1 : win_cnt);
      if (state == FLUSH) stat_grants <= win_cnt;
    end
`endif
endmodule
